approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 6: operand width; SHALL be even, 4..16; H = WIDTH/2.
REQ-002 Parameter CNT_W, default 16: width of the approximate-transaction counter.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand pair offered.
REQ-006 Port in_ready  output  1  block accepts the offered pair this cycle.
REQ-007 Port a  input  WIDTH  unsigned multiplicand.
REQ-008 Port b  input  WIDTH  unsigned multiplier.
REQ-009 Port mode  input  1  0 = exact product, 1 = two-step approximate product; sampled with a/b.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port c  output  2*WIDTH  product (exact or approximate per captured mode).
REQ-013 Port err  output  WIDTH  exact minus approximate value for this transaction.
REQ-014 Port clr_cnt  input  1  synchronous clear of approx_cnt.
REQ-015 Port approx_cnt  output  CNT_W  count of mode-1 results delivered.

Function
REQ-016 Split: a = {ah, al}, b = {bh, bl}, each half H bits, unsigned.
REQ-017 Exact: c = (ah*bh << 2H) + ((ah*bl + al*bh) << H) + al*bl, equal to a*b.
REQ-018 Approximate (mode 1): c = (ah*bh << 2H) + ((ah*bl + al*bh) << H); the al*bl term SHALL be dropped.
REQ-019 err SHALL equal al*bl in both modes (informational in mode 0); c + err SHALL always equal a*b.
REQ-020 No intermediate SHALL overflow; middle sum is H*2+1 bits wide, final sum 2*WIDTH bits.
REQ-021 Pipeline SHALL be 3 stages: S1 registers operands, mode and four partial products; S2 registers ah*bh term and middle sum; S3 registers c and err.
REQ-022 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-023 Latency: an accepted pair with no stall SHALL appear at out_valid exactly 3 cycles after acceptance.
REQ-024 Stall: when out_valid && !out_ready, all stages SHALL hold; in_ready SHALL be 0; c, err, out_valid SHALL remain stable.
REQ-025 in_ready = !(out_valid && !out_ready); combinational from S3 valid and out_ready only.
REQ-026 Bubbles SHALL advance with the pipeline when not stalled; no bubble compression required.
REQ-027 Throughput SHALL be one result per cycle with out_ready held high.
REQ-028 Results SHALL leave in acceptance order; mode SHALL travel with its operands (mode changes between transactions take effect per transaction).
REQ-029 approx_cnt SHALL increment by 1 on each output transfer whose captured mode is 1.
REQ-030 approx_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-031 clr_cnt coincident with an increment SHALL win: counter becomes 0.
REQ-032 in_valid low SHALL insert a bubble; a/b/mode are don't-care then.

Reset
REQ-033 rst_n low SHALL immediately clear all stage valids, out_valid, c, err, approx_cnt to 0.
REQ-034 In-flight transactions at reset assertion SHALL be discarded, never delivered.
REQ-035 in_ready SHALL read 1 while rst_n is low; no transfer SHALL be accepted until the first rising edge after rst_n deasserts.

Verification (WIDTH=6, CNT_W=16)
REQ-036 a=63,b=63,mode=0, out_ready=1 -> 3 cycles later c=3969, err=49; mode=1 -> c=3920, err=49, approx_cnt +1.
REQ-037 a=5,b=6,mode=1 -> c=0, err=30; a=40,b=9,mode=1 -> c=360, err=0.
REQ-038 Back-to-back 4096-pair sweep, alternating mode, random out_ready -> every c+err = a*b, order preserved, no loss/duplication, approx_cnt = 2048.
REQ-039 Hold out_ready=0 with 3 pairs in flight -> in_ready=0, c/err/out_valid frozen; release -> 3 results on 3 consecutive cycles.
REQ-040 Preload approx_cnt to 65535 via transfers, one more mode-1 transfer -> stays 65535; clr_cnt with simultaneous transfer -> 0.
REQ-041 Assert rst_n low with 2 pairs in flight -> out_valid=0, c=0, approx_cnt=0 immediately; neither pair is later delivered.

Source files
------------

// File: rtl/approx_mult_pipe.sv
// Three-stage split-operand multiplier; exact or low-term-dropped product with the dropped term as err.
// Latency 3 cycles; a stalled output freezes every stage and in_ready falls.
module approx_mult_pipe #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic [WIDTH-1:0]     err,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     approx_cnt
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H;
    localparam int MW = 2 * H + 1;
    localparam int OW = 2 * WIDTH;

    logic [PW-1:0] ah_x, al_x, bh_x, bl_x;
    logic          advance;

    logic          v1, m1;
    logic [PW-1:0] hh1, hl1, lh1, ll1;

    logic          v2, m2;
    logic [PW-1:0] hh2, ll2;
    logic [MW-1:0] mid2;

    logic          v3, m3;
    logic [OW-1:0] c_q;
    logic [WIDTH-1:0] err_q;
    logic [CNT_W-1:0] cnt;

    logic [OW-1:0] hh_term, mid_term, ll_term;

    assign ah_x = {{H{1'b0}}, a[WIDTH-1:H]};
    assign al_x = {{H{1'b0}}, a[H-1:0]};
    assign bh_x = {{H{1'b0}}, b[WIDTH-1:H]};
    assign bl_x = {{H{1'b0}}, b[H-1:0]};

    // The whole pipe moves as one; only a held result blocks it.
    assign advance  = !(v3 && !out_ready);
    assign in_ready = advance;

    assign hh_term  = {hh2, {PW{1'b0}}};
    assign mid_term = {{(OW-MW-H){1'b0}}, mid2, {H{1'b0}}};
    assign ll_term  = m2 ? {OW{1'b0}} : {{(OW-PW){1'b0}}, ll2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            m1    <= 1'b0;
            hh1   <= '0;
            hl1   <= '0;
            lh1   <= '0;
            ll1   <= '0;
            v2    <= 1'b0;
            m2    <= 1'b0;
            hh2   <= '0;
            ll2   <= '0;
            mid2  <= '0;
            v3    <= 1'b0;
            m3    <= 1'b0;
            c_q   <= '0;
            err_q <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            m1    <= mode;
            hh1   <= ah_x * bh_x;
            hl1   <= ah_x * bl_x;
            lh1   <= al_x * bh_x;
            ll1   <= al_x * bl_x;
            v2    <= v1;
            m2    <= m1;
            hh2   <= hh1;
            ll2   <= ll1;
            mid2  <= {1'b0, hl1} + {1'b0, lh1};
            v3    <= v2;
            m3    <= m2;
            c_q   <= hh_term + mid_term + ll_term;
            err_q <= ll2;
        end
    end

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (v3 && out_ready && m3 && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = v3;
    assign c          = c_q;
    assign err        = err_q;
    assign approx_cnt = cnt;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboarded bench for approx_mult_pipe: directed vectors, stall, full sweep, saturation, reset flush.
module tb_approx_mult_pipe;
    localparam int WIDTH = 6;
    localparam int CNT_W = 12;  // small counter so saturation is reachable quickly

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, mode, out_valid, out_ready, clr_cnt;
    logic [5:0]       a, b, err;
    logic [11:0]      c;
    logic [CNT_W-1:0] approx_cnt;

    typedef struct packed {
        logic [11:0] c;
        logic [5:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;

    approx_mult_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .err(err), .clr_cnt(clr_cnt), .approx_cnt(approx_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] ta, input logic [5:0] tb_, input logic tm);
        exp_t        r;
        logic [11:0] p;
        logic [5:0]  ll;
        p     = {6'b0, ta} * {6'b0, tb_};
        ll    = {3'b0, ta[2:0]} * {3'b0, tb_[2:0]};
        r.c   = tm ? p - {6'b0, ll} : p;
        r.err = ll;
        return r;
    endfunction

    // Handshakes are stable at the falling edge; pop before push so a stray output is never masked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_c", 32'(c), 32'(e.c));
                    chk("sb_err", 32'(err), 32'(e.err));
                    n_out++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while ((sb.size() != 0 || out_valid) && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input logic [5:0] ta, input logic [5:0] tb_, input logic tm,
                            input logic [11:0] ec, input logic [5:0] ee, input logic [CNT_W-1:0] ecnt);
        a = ta; b = tb_; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("lat_early", 32'(out_valid), 32'd0);
        tick();
        chk("lat_vld", 32'(out_valid), 32'd1);
        chk("dir_c", 32'(c), 32'(ec));
        chk("dir_err", 32'(err), 32'(ee));
        tick();
        chk("dir_cnt", 32'(approx_cnt), 32'(ecnt));
    endtask

    initial begin
        int   i, guard, n0;
        logic acc;
        exp_t x1, x2, x3;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(approx_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        directed(6'd63, 6'd63, 1'b0, 12'd3969, 6'd49, 12'd0);
        directed(6'd63, 6'd63, 1'b1, 12'd3920, 6'd49, 12'd1);
        directed(6'd5,  6'd6,  1'b1, 12'd0,    6'd30, 12'd2);
        directed(6'd40, 6'd9,  1'b1, 12'd360,  6'd0,  12'd3);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(approx_cnt), 32'd0);

        // Exhaustive sweep, alternating mode, random backpressure.
        n0 = n_out; i = 0; guard = 0;
        while (i < 4096 && guard < 40000) begin
            a = i[11:6]; b = i[5:0]; mode = i[0]; in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        if (guard >= 40000) chk("sweep_timeout", 32'd1, 32'd0);
        drain();
        chk("sweep_count", 32'(n_out - n0), 32'd4096);
        chk("sweep_cnt", 32'(approx_cnt), 32'd2048);

        // Fill the counter to its ceiling, then one more approximate result.
        for (int k = 0; k < 2047; k++) begin
            a = 6'($urandom); b = 6'($urandom); mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            tick();
        end
        drain();
        chk("sat_reach", 32'(approx_cnt), 32'd4095);
        directed(6'd63, 6'd63, 1'b1, 12'd3920, 6'd49, 12'd4095);

        // Clear coincident with a mode-1 output transfer.
        out_ready = 1'b0;
        a = 6'd21; b = 6'd13; mode = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("clr_race_vld", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1; out_ready = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_race_cnt", 32'(approx_cnt), 32'd0);
        drain();

        // Stall with three pairs in flight.
        x1 = model(6'd10, 6'd20, 1'b1);
        x2 = model(6'd33, 6'd17, 1'b1);
        x3 = model(6'd62, 6'd45, 1'b1);
        out_ready = 1'b0; mode = 1'b1; in_valid = 1'b1;
        a = 6'd10; b = 6'd20; tick();
        a = 6'd33; b = 6'd17; tick();
        a = 6'd62; b = 6'd45; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_vld", 32'(out_valid), 32'd1);
            chk("stall_c", 32'(c), 32'(x1.c));
            chk("stall_err", 32'(err), 32'(x1.err));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("release_vld2", 32'(out_valid), 32'd1);
        chk("release_c2", 32'(c), 32'(x2.c));
        tick();
        chk("release_vld3", 32'(out_valid), 32'd1);
        chk("release_c3", 32'(c), 32'(x3.c));
        tick();
        chk("release_empty", 32'(out_valid), 32'd0);
        chk("release_cnt", 32'(approx_cnt), 32'd3);

        // Reset with two pairs in flight; neither may emerge afterwards.
        out_ready = 1'b0; mode = 1'b1; in_valid = 1'b1;
        a = 6'd7;  b = 6'd9;  tick();
        a = 6'd12; b = 6'd50; mode = 1'b0; tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_c", 32'(c), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_cnt", 32'(approx_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        n0 = n_out;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("flush_vld", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(n_out - n0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
